fp_result_checker: RTL and testbench
====================================

# fp_result_checker

Synthesizable, parametrised scoreboard for the floating-point unit. It queues expected results and flags in a FIFO, then matches them in order against results the unit under test returns with `ready` asserted, so latency is variable rather than a fixed pipeline depth. It applies the canonical-NaN relaxation, counts passes and failures, and detects orphan results and timeouts. It can either halt on the first failure or run to completion. It sits beside `fp_unit` in simulation benches and on-chip self-test harnesses.

## Interface
- DEPTH, 8: expected-entry FIFO depth; power of two, ≥2.
- STOP_ON_FAIL, 1: 1 = halt on first mismatch; 0 = count and continue.
- TIMEOUT, 1024: max cycles with FIFO non-empty and no `dut_ready`; 0 disables the check.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- exp_valid  in  1  push one expected entry.
- exp_ready  out  1  FIFO can accept (not full and state RUN).
- exp_result  in  64  expected result.
- exp_flags  in  5  expected flags.
- exp_fmt  in  2  0 = single, 1 = double.
- exp_nan_ok  in  1  canonical-NaN relaxation allowed (0 for compare and float→int ops).
- exp_last  in  1  final vector marker.
- dut_ready  in  1  unit-under-test result valid this cycle.
- dut_result  in  64  calculated result.
- dut_flags  in  5  calculated flags.
- err_valid  out  1  one-cycle pulse: mismatch recorded.
- err_result_diff  out  64  masked result XOR of the last mismatch.
- err_flags_diff  out  5  flags XOR of the last mismatch.
- err_index  out  32  ordinal (0-based) of the failing entry.
- pass_count  out  32  matched entries, saturating.
- fail_count  out  32  mismatched entries, saturating.
- orphan  out  1  sticky: `dut_ready` seen with the FIFO empty.
- timeout  out  1  sticky: timeout expired.
- done  out  1  state is DONE or HALT.
- pass  out  1  done, fail_count=0, orphan=0, timeout=0.

## Operation
- **FIFO.** Push when `exp_valid && exp_ready`. Pop when `dut_ready` and the FIFO is non-empty. Push and pop in the same cycle are both allowed, including when full (the pop frees a slot but `exp_ready` stays low because it is computed from the current count) and when empty.
- **No bypass.** A `dut_ready` arriving in the same cycle as a push into an empty FIFO is an orphan.
- **Comparison** is combinational against the FIFO head:
  - fmt 0, `nan_ok`, and `dut_result[31:0]` = 7FC00000: diff = {32'h0, 1'b0, dut[30:22]^exp[30:22], 22'h0}.
  - fmt 1, `nan_ok`, and `dut_result` = 7FF8000000000000: diff = {1'b0, dut[62:51]^exp[62:51], 51'h0}.
  - Otherwise: diff = `dut_result` ^ `exp_result`.
  - Mismatch = diff≠0 or flags diff≠0.
- **Entry counter** (32 bit) increments on every pop.
- **State machine** (states RUN, HALT, DONE):
  - RUN→HALT: a mismatch with STOP_ON_FAIL=1, orphan, or timeout.
  - RUN→DONE: popped entry has `last`=1. If that entry mismatches with STOP_ON_FAIL=1, HALT takes priority.
  - HALT and DONE are terminal until reset.
  - In HALT or DONE: `exp_ready`=0, pops stop, counters freeze.
- **Timeout counter** resets on a pop or when the FIFO is empty, and increments otherwise. The timeout fires when the count reaches TIMEOUT.
- **Counters** saturate at FFFFFFFF.
- **Reset** values:
  - All outputs 0, except `exp_ready`, which goes to 1 on the first cycle after reset release.
  - FIFO empty, state RUN.
  - Reset mid-run discards all queued entries.

## Timing
- `err_valid`, `err_*`, counters, `orphan`, `timeout`, `done`, `pass`: registered, updated the cycle after the triggering `dut_ready` or timeout edge.
- `exp_ready`: registered from the count, state, and `reset`.
- Sustained throughput: one push and one pop per cycle.
- `pass` is valid only while `done`=1.

## Test plan
- **In-order match.** Push 4 single-precision entries (3F800000, flags 0; last on the 4th). Return them with gaps of 1, 3, 0, 5 cycles. Required: `pass_count`=4, `done`=1, `pass`=1, `err_valid` never asserted.
- **NaN relaxation.** Expected 7FC00001, DUT 7FC00000, `nan_ok`=1 → match. Same pair with `nan_ok`=0 → `err_result_diff`=00000001, `err_index`=0, HALT.
- **Double-precision mask.** Expected FFF8000000000000, DUT 7FF8000000000000, `nan_ok`=1 → diff=0, match.
- **Count-and-continue.** STOP_ON_FAIL=0, 8 entries, entries 2 and 5 with flags differing by 01. Required: `fail_count`=2, `pass_count`=6, last `err_index`=5, `done`=1, `pass`=0.
- **Full / orphan.** Push 8 entries, DEPTH=8: `exp_ready`=0. A simultaneous push and pop keeps the count at 8. Then `dut_ready` on an empty FIFO → `orphan`=1, HALT.
- **Timeout and reset.** TIMEOUT=16, push 1 entry, no `dut_ready`. Required: `timeout`=1 on cycle 17, `done`=1. Assert reset mid-HALT: all outputs return to 0 and the FIFO is empty.

Source files
------------

// File: rtl/fp_result_checker.sv
// In-order result scoreboard for the floating-point unit: queues expected results,
// matches them against returned results with canonical-NaN relaxation, and tracks verdicts.
module fp_result_checker #(
    parameter int DEPTH        = 8,
    parameter int STOP_ON_FAIL = 1,
    parameter int TIMEOUT      = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [63:0] exp_result,
    input  logic [4:0]  exp_flags,
    input  logic [1:0]  exp_fmt,
    input  logic        exp_nan_ok,
    input  logic        exp_last,
    input  logic        dut_ready,
    input  logic [63:0] dut_result,
    input  logic [4:0]  dut_flags,
    output logic        err_valid,
    output logic [63:0] err_result_diff,
    output logic [4:0]  err_flags_diff,
    output logic [31:0] err_index,
    output logic [31:0] pass_count,
    output logic [31:0] fail_count,
    output logic        orphan,
    output logic        timeout,
    output logic        done,
    output logic        pass
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT  = (AW + 1)'(0);
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);
    localparam logic        STOP_EN   = (STOP_ON_FAIL != 0);
    localparam logic        TMO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        DONE = 2'd2
    } state_t;

    // A canonical NaN from the unit only has to agree with the expected NaN on exponent and quiet bit.
    function automatic logic [63:0] masked_diff(input logic [63:0] e, input logic [63:0] d,
                                                input logic [1:0] fmt, input logic nan_ok);
        logic [63:0] x;
        x = d ^ e;
        if (nan_ok && (fmt == 2'd0) && (d[31:0] == 32'h7FC0_0000)) begin
            masked_diff = {32'h0, 1'b0, x[30:22], 22'h0};
        end else if (nan_ok && (fmt == 2'd1) && (d == 64'h7FF8_0000_0000_0000)) begin
            masked_diff = {1'b0, x[62:51], 51'h0};
        end else begin
            masked_diff = x;
        end
    endfunction

    logic [63:0] fifo_result_r [DEPTH];
    logic [4:0]  fifo_flags_r  [DEPTH];
    logic [1:0]  fifo_fmt_r    [DEPTH];
    logic        fifo_nan_ok_r [DEPTH];
    logic        fifo_last_r   [DEPTH];

    state_t      state_r, state_nxt_s;
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0] count_r, count_nxt_s;
    logic [31:0] entry_cnt_r, tmo_cnt_r, tmo_cnt_nxt_s;
    logic        exp_ready_r, err_valid_r, orphan_r, timeout_r, done_r, pass_r;
    logic [63:0] err_result_diff_r;
    logic [4:0]  err_flags_diff_r;
    logic [31:0] err_index_r, pass_count_r, fail_count_r;
    logic [31:0] pass_cnt_nxt_s, fail_cnt_nxt_s;
    logic        orphan_nxt_s, timeout_nxt_s, pass_nxt_s;

    logic        run_s, empty_s, full_s, push_s, pop_s, mismatch_s;
    logic        fail_evt_s, pass_evt_s, orphan_evt_s, tmo_evt_s;
    logic [63:0] rdiff_s;
    logic [4:0]  fdiff_s;

    // Expected-entry storage; validity is tracked by count_r so the data needs no reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_result_r[wr_ptr_r] <= exp_result;
            fifo_flags_r[wr_ptr_r]  <= exp_flags;
            fifo_fmt_r[wr_ptr_r]    <= exp_fmt;
            fifo_nan_ok_r[wr_ptr_r] <= exp_nan_ok;
            fifo_last_r[wr_ptr_r]   <= exp_last;
        end
    end

    // Head comparison, event decode and next-state/next-counter computation.
    always_comb begin
        run_s        = (state_r == RUN);
        empty_s      = (count_r == ZERO_CNT);
        full_s       = (count_r == FULL_CNT);
        pop_s        = run_s && dut_ready && !empty_s;
        // A full FIFO still takes a push alongside a pop; exp_ready only reflects the count.
        push_s       = exp_valid && (exp_ready_r || (full_s && pop_s));
        rdiff_s      = masked_diff(fifo_result_r[rd_ptr_r], dut_result,
                                   fifo_fmt_r[rd_ptr_r], fifo_nan_ok_r[rd_ptr_r]);
        fdiff_s      = dut_flags ^ fifo_flags_r[rd_ptr_r];
        mismatch_s   = (rdiff_s != 64'h0) || (fdiff_s != 5'h0);
        fail_evt_s   = pop_s && mismatch_s;
        pass_evt_s   = pop_s && !mismatch_s;
        orphan_evt_s = run_s && dut_ready && empty_s;
        tmo_evt_s    = run_s && TMO_EN && !empty_s && !pop_s && (tmo_cnt_r == TMO_LIMIT);

        case (state_r)
            RUN: begin
                if ((fail_evt_s && STOP_EN) || orphan_evt_s || tmo_evt_s) begin
                    state_nxt_s = HALT;
                end else if (pop_s && fifo_last_r[rd_ptr_r]) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HALT:    state_nxt_s = HALT;
            DONE:    state_nxt_s = DONE;
            default: state_nxt_s = HALT;
        endcase

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (AW + 1)'(1);
            2'b01:   count_nxt_s = count_r - (AW + 1)'(1);
            default: count_nxt_s = count_r;
        endcase

        if (!run_s) begin
            tmo_cnt_nxt_s = tmo_cnt_r;
        end else if (pop_s || empty_s) begin
            tmo_cnt_nxt_s = 32'h0;
        end else if (tmo_cnt_r != 32'hFFFF_FFFF) begin
            tmo_cnt_nxt_s = tmo_cnt_r + 32'h1;
        end else begin
            tmo_cnt_nxt_s = tmo_cnt_r;
        end

        if (pass_evt_s && (pass_count_r != 32'hFFFF_FFFF)) begin
            pass_cnt_nxt_s = pass_count_r + 32'h1;
        end else begin
            pass_cnt_nxt_s = pass_count_r;
        end

        if (fail_evt_s && (fail_count_r != 32'hFFFF_FFFF)) begin
            fail_cnt_nxt_s = fail_count_r + 32'h1;
        end else begin
            fail_cnt_nxt_s = fail_count_r;
        end

        orphan_nxt_s  = orphan_r | orphan_evt_s;
        timeout_nxt_s = timeout_r | tmo_evt_s;
        pass_nxt_s    = (state_nxt_s != RUN) && (fail_cnt_nxt_s == 32'h0) &&
                        !orphan_nxt_s && !timeout_nxt_s;
    end

    // State machine, FIFO pointers and all registered verdict outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r           <= RUN;
            wr_ptr_r          <= AW'(0);
            rd_ptr_r          <= AW'(0);
            count_r           <= ZERO_CNT;
            entry_cnt_r       <= 32'h0;
            tmo_cnt_r         <= 32'h0;
            exp_ready_r       <= 1'b0;
            err_valid_r       <= 1'b0;
            err_result_diff_r <= 64'h0;
            err_flags_diff_r  <= 5'h0;
            err_index_r       <= 32'h0;
            pass_count_r      <= 32'h0;
            fail_count_r      <= 32'h0;
            orphan_r          <= 1'b0;
            timeout_r         <= 1'b0;
            done_r            <= 1'b0;
            pass_r            <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            count_r   <= count_nxt_s;
            tmo_cnt_r <= tmo_cnt_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r    <= rd_ptr_r + AW'(1);
                entry_cnt_r <= entry_cnt_r + 32'h1;
            end
            err_valid_r <= fail_evt_s;
            if (fail_evt_s) begin
                err_result_diff_r <= rdiff_s;
                err_flags_diff_r  <= fdiff_s;
                err_index_r       <= entry_cnt_r;
            end
            pass_count_r <= pass_cnt_nxt_s;
            fail_count_r <= fail_cnt_nxt_s;
            orphan_r     <= orphan_nxt_s;
            timeout_r    <= timeout_nxt_s;
            done_r       <= (state_nxt_s != RUN);
            pass_r       <= pass_nxt_s;
            exp_ready_r  <= (state_nxt_s == RUN) && (count_nxt_s != FULL_CNT);
        end
    end

    assign exp_ready       = exp_ready_r;
    assign err_valid       = err_valid_r;
    assign err_result_diff = err_result_diff_r;
    assign err_flags_diff  = err_flags_diff_r;
    assign err_index       = err_index_r;
    assign pass_count      = pass_count_r;
    assign fail_count      = fail_count_r;
    assign orphan          = orphan_r;
    assign timeout         = timeout_r;
    assign done            = done_r;
    assign pass            = pass_r;

endmodule

// File: tb/tb_fp_result_checker.sv
// Bench for fp_result_checker: a vector table plus hand-written sequences, checked
// through a scoreboard queue of expected mismatch records.
module tb_fp_result_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exp_valid = 1'b0, exp_nan_ok = 1'b0, exp_last = 1'b0, dut_ready = 1'b0;
    logic [63:0] exp_result = 64'h0, dut_result = 64'h0;
    logic [4:0]  exp_flags = 5'h0, dut_flags = 5'h0;
    logic [1:0]  exp_fmt = 2'd0;

    logic        a_exp_ready, a_err_valid, a_orphan, a_timeout, a_done, a_pass;
    logic [63:0] a_rdiff;
    logic [4:0]  a_fdiff;
    logic [31:0] a_idx, a_pc, a_fc;
    logic        b_exp_ready, b_err_valid, b_orphan, b_timeout, b_done, b_pass;
    logic [63:0] b_rdiff;
    logic [4:0]  b_fdiff;
    logic [31:0] b_idx, b_pc, b_fc;

    logic        sel_b = 1'b0;
    logic        c_exp_ready, c_err_valid;
    logic [63:0] c_rdiff;
    logic [4:0]  c_fdiff;
    logic [31:0] c_idx;

    typedef struct {
        logic        mism;
        logic [63:0] rd;
        logic [4:0]  fd;
        logic [31:0] idx;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [63:0] er;
        logic [4:0]  ef;
        logic [1:0]  fmt;
        logic        nan;
        logic [63:0] dr;
        logic [4:0]  df;
        logic        mism;
        logic [63:0] rd;
        logic [4:0]  fd;
    } vec_t;
    vec_t vt[13];

    int          checks = 0;
    int          errors = 0;
    int          a_err_pulses = 0;
    int          pulses_before;
    logic [31:0] n_idx = 32'h0;

    always #5 clock = ~clock;

    fp_result_checker #(.DEPTH(8), .STOP_ON_FAIL(1), .TIMEOUT(16)) dut_a (
        .clock(clock), .reset(reset), .exp_valid(exp_valid), .exp_ready(a_exp_ready),
        .exp_result(exp_result), .exp_flags(exp_flags), .exp_fmt(exp_fmt),
        .exp_nan_ok(exp_nan_ok), .exp_last(exp_last), .dut_ready(dut_ready),
        .dut_result(dut_result), .dut_flags(dut_flags), .err_valid(a_err_valid),
        .err_result_diff(a_rdiff), .err_flags_diff(a_fdiff), .err_index(a_idx),
        .pass_count(a_pc), .fail_count(a_fc), .orphan(a_orphan), .timeout(a_timeout),
        .done(a_done), .pass(a_pass)
    );

    fp_result_checker #(.DEPTH(8), .STOP_ON_FAIL(0), .TIMEOUT(0)) dut_b (
        .clock(clock), .reset(reset), .exp_valid(exp_valid), .exp_ready(b_exp_ready),
        .exp_result(exp_result), .exp_flags(exp_flags), .exp_fmt(exp_fmt),
        .exp_nan_ok(exp_nan_ok), .exp_last(exp_last), .dut_ready(dut_ready),
        .dut_result(dut_result), .dut_flags(dut_flags), .err_valid(b_err_valid),
        .err_result_diff(b_rdiff), .err_flags_diff(b_fdiff), .err_index(b_idx),
        .pass_count(b_pc), .fail_count(b_fc), .orphan(b_orphan), .timeout(b_timeout),
        .done(b_done), .pass(b_pass)
    );

    // Route the instance under scoreboard watch.
    always_comb begin
        c_exp_ready = sel_b ? b_exp_ready : a_exp_ready;
        c_err_valid = sel_b ? b_err_valid : a_err_valid;
        c_rdiff     = sel_b ? b_rdiff     : a_rdiff;
        c_fdiff     = sel_b ? b_fdiff     : a_fdiff;
        c_idx       = sel_b ? b_idx       : a_idx;
    end

    // Count every mismatch pulse from the stop-on-fail instance.
    always @(negedge clock) begin
        if (a_err_valid) a_err_pulses++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic do_reset(input bit check_outs);
        reset = 1'b0; exp_valid = 1'b0; dut_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        if (check_outs) begin
            chk("rst_exp_ready", a_exp_ready, 64'h0);
            chk("rst_err_valid", a_err_valid, 64'h0);
            chk("rst_pass_count", a_pc, 64'h0);
            chk("rst_fail_count", a_fc, 64'h0);
            chk("rst_done", a_done, 64'h0);
            chk("rst_pass", a_pass, 64'h0);
            chk("rst_orphan_timeout", {a_orphan, a_timeout}, 64'h0);
        end
        sb_q.delete();
        n_idx = 32'h0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("release_exp_ready", c_exp_ready, 64'h1);
    endtask

    task automatic push(input logic [63:0] r, input logic [4:0] f, input logic [1:0] fmt,
                        input logic nan, input logic last);
        int w = 0;
        while (!c_exp_ready && w < 20) begin
            @(posedge clock);
            #1;
            w++;
        end
        if (!c_exp_ready) begin
            checks++; errors++;
            $display("FAIL push_wait: exp_ready still 0 after %0d cycles", w);
        end
        exp_result = r; exp_flags = f; exp_fmt = fmt; exp_nan_ok = nan; exp_last = last;
        exp_valid = 1'b1;
        @(posedge clock);
        #1;
        exp_valid = 1'b0;
    endtask

    task automatic sb_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: no expected record queued");
            return;
        end
        e = sb_q.pop_front();
        chk("sb_err_valid", c_err_valid, e.mism);
        if (e.mism) begin
            chk("sb_result_diff", c_rdiff, e.rd);
            chk("sb_flags_diff", c_fdiff, e.fd);
            chk("sb_index", c_idx, e.idx);
        end
    endtask

    task automatic ret(input logic [63:0] r, input logic [4:0] f, input logic mism,
                       input logic [63:0] rd, input logic [4:0] fd);
        dut_result = r; dut_flags = f; dut_ready = 1'b1;
        sb_q.push_back('{mism, rd, fd, n_idx});
        n_idx++;
        @(posedge clock);
        #1;
        dut_ready = 1'b0;
        sb_check();
    endtask

    task automatic orphan_pulse();
        dut_result = 64'h0; dut_flags = 5'h0; dut_ready = 1'b1;
        @(posedge clock);
        #1;
        dut_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps[4];
        gaps = '{1, 3, 0, 5};
        vt[0]  = '{64'h3F80_0000, 5'h00, 2'd0, 1'b1, 64'h3F80_0000, 5'h00, 1'b0, 64'h0, 5'h00};
        vt[1]  = '{64'h7FC0_0001, 5'h00, 2'd0, 1'b1, 64'h7FC0_0000, 5'h00, 1'b0, 64'h0, 5'h00};
        vt[2]  = '{64'h7FC0_0001, 5'h00, 2'd0, 1'b0, 64'h7FC0_0000, 5'h00, 1'b1, 64'h1, 5'h00};
        vt[3]  = '{64'hFFF8_0000_0000_0000, 5'h00, 2'd1, 1'b1, 64'h7FF8_0000_0000_0000, 5'h00,
                   1'b0, 64'h0, 5'h00};
        vt[4]  = '{64'hFFF8_0000_0000_0000, 5'h00, 2'd1, 1'b0, 64'h7FF8_0000_0000_0000, 5'h00,
                   1'b1, 64'h8000_0000_0000_0000, 5'h00};
        vt[5]  = '{64'h1234_5678_FFC0_0000, 5'h00, 2'd0, 1'b1, 64'h7FC0_0000, 5'h00,
                   1'b0, 64'h0, 5'h00};
        vt[6]  = '{64'h7F80_0000, 5'h00, 2'd0, 1'b1, 64'h7FC0_0000, 5'h00, 1'b1, 64'h0040_0000, 5'h00};
        vt[7]  = '{64'h7FF0_0000_0000_0000, 5'h00, 2'd1, 1'b1, 64'h7FF8_0000_0000_0000, 5'h00,
                   1'b1, 64'h0008_0000_0000_0000, 5'h00};
        vt[8]  = '{64'h4000_0000, 5'h01, 2'd0, 1'b0, 64'h4000_0000, 5'h00, 1'b1, 64'h0, 5'h01};
        vt[9]  = '{64'h0000_0001_7FC0_0000, 5'h00, 2'd1, 1'b1, 64'h7FC0_0000, 5'h00,
                   1'b1, 64'h0000_0001_0000_0000, 5'h00};
        vt[10] = '{64'h7FC0_0001, 5'h00, 2'd2, 1'b1, 64'h7FC0_0000, 5'h00, 1'b1, 64'h1, 5'h00};
        vt[11] = '{64'h7FC0_0000, 5'h00, 2'd0, 1'b1, 64'h7FC0_0001, 5'h00, 1'b1, 64'h1, 5'h00};
        vt[12] = '{64'h7FC0_0000, 5'h10, 2'd0, 1'b1, 64'h7FC0_0000, 5'h00, 1'b1, 64'h0, 5'h10};

        do_reset(1'b1);

        // In-order match with variable return gaps.
        pulses_before = a_err_pulses;
        for (int i = 0; i < 4; i++) push(64'h3F80_0000, 5'h00, 2'd0, 1'b1, (i == 3));
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("inorder_not_done", a_done, 64'h0);
            repeat (gaps[i]) @(posedge clock);
            #1;
            ret(64'h3F80_0000, 5'h00, 1'b0, 64'h0, 5'h00);
        end
        chk("inorder_pass_count", a_pc, 64'd4);
        chk("inorder_done", a_done, 64'h1);
        chk("inorder_pass", a_pass, 64'h1);
        chk("inorder_no_err", 64'(a_err_pulses - pulses_before), 64'h0);

        // Single-entry vectors: NaN relaxation, masks and plain differences.
        for (int i = 0; i < 13; i++) begin
            do_reset(1'b0);
            push(vt[i].er, vt[i].ef, vt[i].fmt, vt[i].nan, 1'b1);
            ret(vt[i].dr, vt[i].df, vt[i].mism, vt[i].rd, vt[i].fd);
            chk($sformatf("vec%0d_done", i), a_done, 64'h1);
            chk($sformatf("vec%0d_pass", i), a_pass, {63'h0, !vt[i].mism});
            chk($sformatf("vec%0d_pass_count", i), a_pc, {63'h0, !vt[i].mism});
            chk($sformatf("vec%0d_fail_count", i), a_fc, {63'h0, vt[i].mism});
            chk($sformatf("vec%0d_result_diff", i), a_rdiff, vt[i].mism ? vt[i].rd : 64'h0);
        end

        // Count-and-continue on the non-stopping instance.
        sel_b = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < 8; i++)
            push(64'h3F80_0000 + 64'(i), (i == 2 || i == 5) ? 5'h01 : 5'h00, 2'd0, 1'b1, (i == 7));
        for (int i = 0; i < 8; i++) begin
            if (i == 2 || i == 5) ret(64'h3F80_0000 + 64'(i), 5'h00, 1'b1, 64'h0, 5'h01);
            else                  ret(64'h3F80_0000 + 64'(i), 5'h00, 1'b0, 64'h0, 5'h00);
        end
        chk("cont_fail_count", b_fc, 64'd2);
        chk("cont_pass_count", b_pc, 64'd6);
        chk("cont_err_index", b_idx, 64'd5);
        chk("cont_done", b_done, 64'h1);
        chk("cont_pass", b_pass, 64'h0);
        chk("stop_fail_count", a_fc, 64'd1);
        chk("stop_pass_count", a_pc, 64'd2);
        chk("stop_err_index", a_idx, 64'd2);
        chk("stop_done", a_done, 64'h1);
        sel_b = 1'b0;

        // Full FIFO, simultaneous push and pop, drain, then an orphan.
        do_reset(1'b0);
        pulses_before = a_err_pulses;
        for (int i = 0; i < 8; i++) push(64'h4000_0000, 5'h00, 2'd0, 1'b0, 1'b0);
        chk("full_exp_ready", a_exp_ready, 64'h0);
        exp_result = 64'h4000_0000; exp_flags = 5'h00; exp_fmt = 2'd0;
        exp_nan_ok = 1'b0; exp_last = 1'b0; exp_valid = 1'b1;
        ret(64'h4000_0000, 5'h00, 1'b0, 64'h0, 5'h00);
        exp_valid = 1'b0;
        chk("full_pushpop_exp_ready", a_exp_ready, 64'h0);
        for (int i = 0; i < 8; i++) begin
            ret(64'h4000_0000, 5'h00, 1'b0, 64'h0, 5'h00);
            if (i == 0) chk("drain_exp_ready", a_exp_ready, 64'h1);
        end
        chk("drain_not_done", a_done, 64'h0);
        orphan_pulse();
        chk("orphan_flag", a_orphan, 64'h1);
        chk("orphan_done", a_done, 64'h1);
        chk("orphan_pass", a_pass, 64'h0);
        chk("orphan_pass_count", a_pc, 64'd9);
        chk("orphan_no_err", 64'(a_err_pulses - pulses_before), 64'h0);

        // Timeout after 16 idle cycles, then reset in HALT.
        do_reset(1'b0);
        push(64'h3F80_0000, 5'h00, 2'd0, 1'b1, 1'b0);
        repeat (16) @(posedge clock);
        #1;
        chk("timeout_early", a_timeout, 64'h0);
        @(posedge clock);
        #1;
        chk("timeout_flag", a_timeout, 64'h1);
        chk("timeout_done", a_done, 64'h1);
        chk("timeout_pass", a_pass, 64'h0);
        chk("timeout_exp_ready", a_exp_ready, 64'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("halt_rst_outputs", {a_exp_ready, a_err_valid, a_orphan, a_timeout, a_done, a_pass}, 64'h0);
        chk("halt_rst_counts", {a_pc, a_fc}, 64'h0);
        chk("halt_rst_err", {a_rdiff[58:0], a_fdiff}, 64'h0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("halt_release_exp_ready", a_exp_ready, 64'h1);
        orphan_pulse();
        chk("post_rst_fifo_empty", a_orphan, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
